// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser
//   ASCII peek/poke command engine placed behind a UART. It pops bytes from the
//   RX FIFO and parses "Waadd<CR>" (write) and "Raa<CR>" (read) frames. Command
//   letters and hex digits are accepted in either case. Each accepted frame
//   issues one single-cycle access on an 8-bit register bus, then an ASCII reply
//   is pushed into the TX FIFO:
//     write -> "K<CR>", read -> "HL<CR>" (uppercase hex), error -> "E<CR>".
//   A frame stalled mid-way for 2^TO_BITS-1 cycles is abandoned without a reply.
//
// Ports
//   clk_i, reset_i     clock, asynchronous active-high reset
//   rx_empty_i         RX FIFO empty flag
//   r_data_i           RX FIFO head byte
//   rd_uart_o          RX pop strobe, asserted in the cycle r_data_i is consumed
//   tx_full_i          TX FIFO full flag
//   wr_uart_o          TX push strobe
//   w_data_o           TX byte, valid with wr_uart_o
//   bus_addr_o         register address, held between accesses
//   bus_wdata_o        register write data, held between writes
//   bus_we_o           one-cycle write strobe
//   bus_re_o           one-cycle read strobe; bus_rdata_i is sampled next cycle
//   bus_rdata_i        register read data
//   err_cnt_o          saturating count of rejected or abandoned frames
//
// state    | meaning
// IDLE     | waiting for W/w/R/r; CR and LF are dropped
// ADDR_H   | expecting high address nibble
// ADDR_L   | expecting low address nibble
// DATA_H   | expecting high data nibble (write only)
// DATA_L   | expecting low data nibble (write only)
// EOL      | expecting the terminating CR
// EXEC     | one-cycle bus strobe
// RD_WAIT  | capturing bus_rdata_i
// SEND     | pushing the response buffer into the TX FIFO
// DRAIN    | discarding a bad frame up to and including its CR

module uart_cmd_parser #(
    parameter int ADDR_W  = 8,
    parameter int TO_BITS = 20
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              rx_empty_i,
    input  logic [7:0]        r_data_i,
    output logic              rd_uart_o,
    input  logic              tx_full_i,
    output logic              wr_uart_o,
    output logic [7:0]        w_data_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [7:0]        bus_wdata_o,
    output logic              bus_we_o,
    output logic              bus_re_o,
    input  logic [7:0]        bus_rdata_i,
    output logic [7:0]        err_cnt_o
);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR_H, S_ADDR_L, S_DATA_H, S_DATA_L,
        S_EOL, S_EXEC, S_RD_WAIT, S_SEND, S_DRAIN
    } state_t;

    localparam logic [7:0]         CR     = 8'h0D;
    localparam logic [7:0]         LF     = 8'h0A;
    localparam logic [TO_BITS-1:0] TO_MAX = '1;

    state_t              state_q, state_d;
    logic                is_wr_q, is_wr_d;
    logic [ADDR_W-1:0]   addr_sh_q, addr_sh_d;
    logic [7:0]          data_sh_q, data_sh_d;
    logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
    logic [7:0]          bus_wdata_q, bus_wdata_d;
    logic [2:0][7:0]     resp_q, resp_d;
    logic [1:0]          last_q, last_d;
    logic [1:0]          idx_q, idx_d;
    logic [TO_BITS-1:0]  to_cnt_q, to_cnt_d;
    logic [7:0]          err_cnt_q, err_cnt_d;

    logic                pop;
    logic                do_err;
    logic                err_inc;
    logic [4:0]          hv;
    logic [7:0]          lc;

    // {valid, nibble}
    function automatic logic [4:0] hex_val(input logic [7:0] b);
        logic [7:0] l;
        l = b | 8'h20;
        if (b >= 8'h30 && b <= 8'h39)
            return {1'b1, b[3:0]};
        else if (l >= 8'h61 && l <= 8'h66)
            return {1'b1, l[3:0] + 4'd9};
        else
            return 5'b0;
    endfunction

    function automatic logic [7:0] to_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    // Popping is suppressed while reset is held so a byte is never consumed
    // without the state machine seeing it.
    assign pop = !reset_i && !rx_empty_i &&
                 (state_q inside {S_IDLE, S_ADDR_H, S_ADDR_L, S_DATA_H,
                                  S_DATA_L, S_EOL, S_DRAIN});

    always_comb begin
        state_d     = state_q;
        is_wr_d     = is_wr_q;
        addr_sh_d   = addr_sh_q;
        data_sh_d   = data_sh_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        resp_d      = resp_q;
        last_d      = last_q;
        idx_d       = idx_q;
        to_cnt_d    = to_cnt_q;
        err_cnt_d   = err_cnt_q;
        do_err      = 1'b0;
        err_inc     = 1'b0;
        hv          = hex_val(r_data_i);
        lc          = r_data_i | 8'h20;

        case (state_q)
            S_IDLE: if (pop) begin
                if (r_data_i == CR || r_data_i == LF) begin
                    state_d = S_IDLE;
                end else if (lc == 8'h77 || lc == 8'h72) begin
                    is_wr_d = (lc == 8'h77);
                    state_d = S_ADDR_H;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_ADDR_H, S_ADDR_L, S_DATA_H, S_DATA_L: if (pop) begin
                if (hv[4]) begin
                    case (state_q)
                        S_ADDR_H: begin addr_sh_d[7:4] = hv[3:0]; state_d = S_ADDR_L; end
                        S_ADDR_L: begin
                            addr_sh_d[3:0] = hv[3:0];
                            state_d = is_wr_q ? S_DATA_H : S_EOL;
                        end
                        S_DATA_H: begin data_sh_d[7:4] = hv[3:0]; state_d = S_DATA_L; end
                        default:  begin data_sh_d[3:0] = hv[3:0]; state_d = S_EOL; end
                    endcase
                end else if (r_data_i == CR) begin
                    // Early CR ends the frame, so there is nothing to drain.
                    do_err = 1'b1;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_EOL: if (pop) begin
                if (r_data_i == CR) begin
                    bus_addr_d = addr_sh_q;
                    if (is_wr_q)
                        bus_wdata_d = data_sh_q;
                    state_d = S_EXEC;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_EXEC: begin
                if (is_wr_q) begin
                    resp_d[0] = 8'h4B;
                    resp_d[1] = CR;
                    last_d    = 2'd1;
                    idx_d     = 2'd0;
                    state_d   = S_SEND;
                end else begin
                    state_d = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                resp_d[0] = to_ascii(bus_rdata_i[7:4]);
                resp_d[1] = to_ascii(bus_rdata_i[3:0]);
                resp_d[2] = CR;
                last_d    = 2'd2;
                idx_d     = 2'd0;
                state_d   = S_SEND;
            end
            S_SEND: if (!tx_full_i) begin
                if (idx_q == last_q) begin
                    idx_d   = 2'd0;
                    state_d = S_IDLE;
                end else begin
                    idx_d = idx_q + 2'd1;
                end
            end
            S_DRAIN: if (pop && r_data_i == CR) do_err = 1'b1;
            default: state_d = S_IDLE;
        endcase

        if (do_err) begin
            resp_d[0] = 8'h45;
            resp_d[1] = CR;
            last_d    = 2'd1;
            idx_d     = 2'd0;
            state_d   = S_SEND;
            err_inc   = 1'b1;
        end

        // Inter-byte timeout: reload on every pop, count down only mid-frame.
        if (pop) begin
            to_cnt_d = TO_MAX;
        end else if (state_q inside {S_ADDR_H, S_ADDR_L, S_DATA_H, S_DATA_L, S_EOL}) begin
            to_cnt_d = to_cnt_q - TO_BITS'(1);
            if (to_cnt_q == TO_BITS'(1)) begin
                state_d = S_IDLE;
                err_inc = 1'b1;
            end
        end

        if (err_inc && err_cnt_q != 8'hFF)
            err_cnt_d = err_cnt_q + 8'd1;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            is_wr_q     <= 1'b0;
            addr_sh_q   <= '0;
            data_sh_q   <= '0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            resp_q      <= '0;
            last_q      <= '0;
            idx_q       <= '0;
            to_cnt_q    <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            is_wr_q     <= is_wr_d;
            addr_sh_q   <= addr_sh_d;
            data_sh_q   <= data_sh_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            resp_q      <= resp_d;
            last_q      <= last_d;
            idx_q       <= idx_d;
            to_cnt_q    <= to_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign rd_uart_o   = pop;
    assign wr_uart_o   = (state_q == S_SEND) && !tx_full_i;
    assign w_data_o    = resp_q[idx_q];
    assign bus_addr_o  = bus_addr_q;
    assign bus_wdata_o = bus_wdata_q;
    assign bus_we_o    = (state_q == S_EXEC) && is_wr_q;
    assign bus_re_o    = (state_q == S_EXEC) && !is_wr_q;
    assign err_cnt_o   = err_cnt_q;

endmodule

// File: doc/uart_cmd_parser.md
Name: uart_cmd_parser

Overview:
Byte-level command engine that sits directly downstream of the UART block. It pops received bytes from the UART RX FIFO, parses ASCII register commands, and issues single-cycle accesses on a simple 8-bit register bus. It then pushes an ASCII response into the UART TX FIFO. This gives a host terminal peek/poke access to on-chip registers.

Parameters:
ADDR_W, 8, register bus address width; must be 8 in this revision (two hex digits).
TO_BITS, 20, inter-byte timeout counter width; a frame is abandoned after 2^TO_BITS-1 idle cycles mid-frame.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
rx_empty  input  1  UART RX FIFO empty flag
r_data  input  8  UART RX FIFO head byte; valid while rx_empty=0
rd_uart  output  1  one-cycle pop strobe to the RX FIFO
tx_full  input  1  UART TX FIFO full flag
wr_uart  output  1  one-cycle push strobe to the TX FIFO
w_data  output  8  byte pushed when wr_uart=1
bus_addr  output  8  register address
bus_wdata  output  8  write data
bus_we  output  1  one-cycle write strobe
bus_re  output  1  one-cycle read strobe
bus_rdata  input  8  read data, valid the cycle after bus_re
err_cnt  output  8  saturating count of rejected frames

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - The asynchronous reset forces state=IDLE and clears the timeout counter and response index.
  - Reset values: rd_uart=0, wr_uart=0, w_data=0, bus_addr=0, bus_wdata=0, bus_we=0, bus_re=0, err_cnt=0.
  - Reset mid-frame discards the frame and sends no response.
- RX handshake:
  - A byte is consumed only in a parsing state with rx_empty=0.
  - r_data is sampled and rd_uart=1 in the same cycle.
  - At most one pop per cycle. No pop in EXEC, RD_WAIT or SEND.
- Frame format (no spaces):
  - Write: 'W' a1 a0 d1 d0 CR.
  - Read: 'R' a1 a0 CR.
  - Command letters and hex digits are case-insensitive (0-9, A-F, a-f).
  - In IDLE, CR (0x0D) and LF (0x0A) are discarded silently.
  - In IDLE, any other byte that is not W/w/R/r enters DRAIN.
- States:
  - IDLE -> ADDR_H -> ADDR_L -> (write: DATA_H -> DATA_L ->) EOL -> EXEC.
  - Read path: EXEC -> RD_WAIT -> SEND.
  - Write path: EXEC -> SEND.
  - DRAIN -> SEND (error) on CR.
  - SEND -> IDLE after the last response byte is pushed.
- Hex assembly:
  - Nibble value = digit - '0' for 0-9; (digit|0x20) - 'a' + 10 for letters.
  - High nibble is latched into bits [7:4], low nibble into bits [3:0].
- Invalid byte mid-frame:
  - A non-hex byte in a hex state, or a non-CR byte in EOL, sends the parser to DRAIN.
  - DRAIN discards bytes up to and including CR.
  - A CR arriving early, in ADDR_*/DATA_*, also counts as an error; the error response is queued immediately with no drain.
- EXEC:
  - Write: bus_addr/bus_wdata are driven and bus_we=1 for exactly one cycle.
  - Read: bus_re=1 for one cycle, then RD_WAIT captures bus_rdata the next cycle.
  - bus_addr and bus_wdata hold their values until the next EXEC.
- Responses, loaded into a 3-byte buffer and sent in order:
  - Write: 'K', CR.
  - Read: hi-hex, lo-hex, CR, using uppercase digits (0x0A -> 'A').
  - Error: 'E', CR.
  - In SEND, wr_uart=1 only when tx_full=0. While tx_full=1, w_data and the index hold, with no drop and no duplicate.
- err_cnt: increments by 1 per error response and saturates at 255.
- Timeout:
  - The counter runs in ADDR_H..EOL and clears on every pop.
  - At terminal count the parser returns to IDLE with no response, and err_cnt increments (saturating).
  - The counter is inactive in IDLE, DRAIN and SEND.
- Back-to-back frames: the next frame's bytes wait in the RX FIFO while SEND completes; none are lost.

Test Plan:
- Write "W3C5A\r" with tx_full=0 -> single bus_we pulse, bus_addr=0x3C, bus_wdata=0x5A; TX receives 0x4B, 0x0D; 6 rd_uart pulses total.
- Read "r3c\r" with bus_rdata=0xA7 the cycle after bus_re -> one bus_re pulse, bus_addr=0x3C; TX receives 0x41, 0x37, 0x0D.
- Send "W1G\r" -> no bus strobe, TX receives 'E', CR, err_cnt=1; a following "R00\r" is still answered correctly.
- Read with tx_full held high for 50 cycles during SEND -> wr_uart stays 0 throughout; after release exactly 3 pushes in order; no RX pop until SEND ends.
- Send "W1" then stall for 2^TO_BITS cycles (use TO_BITS=6 in the bench) -> return to IDLE, no TX bytes, err_cnt increments; next "R01\r" works.
- Assert reset during DATA_L of a write -> all outputs return to reset values immediately; no bus_we and no TX byte follow.
